ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage. It consumes operand, function and destination fields as they leave the ID/EX pipeline register. It holds the pipeline through a busy/stall handshake while it iterates, then returns one registered result with its destination register address. Multiplication uses radix-2 shift-add and division uses restoring division, each over 32 iterations on operand magnitudes, followed by a sign-fix cycle.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 supported.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_in  input  1  request from EX; valid M-extension instruction present in ID/EX.
- rs1_data_in  input  32  operand A (dividend / multiplicand).
- rs2_data_in  input  32  operand B (divisor / multiplier).
- func3_in  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- func7_in  input  7  must equal 7'b0000001 for the request to be accepted.
- rd_addr_in  input  5  destination register.
- flush_in  input  1  kill the in-flight operation (branch/exception flush).
- busy_out  output  1  stall request to the PC, IF/ID and ID/EX registers.
- done_out  output  1  one-cycle pulse; result_out and rd_addr_out are valid.
- result_out  output  32  registered result.
- rd_addr_out  output  5  registered destination of the completed operation.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: a request is accepted when start_in=1, func7_in=0000001 and flush_in=0. On acceptance the unit latches func3, rd, operand magnitudes and result-sign flags, clears the 5-bit iteration counter, and moves to CALC. Other func7 values are ignored.
- Signedness:
  - MULH takes both operands as signed.
  - MULHSU takes rs1 as signed and rs2 as unsigned.
  - MULHU and DIVU/REMU take both operands as unsigned.
  - DIV/REM take both operands as signed.
- CALC: one iteration per cycle. Multiply accumulates into a 64-bit product register. Divide shifts a 64-bit remainder:quotient register and does a trial subtract. After the counter reaches 31, the unit moves to FIX.
- FIX: applies two's-complement negation where a sign flag is set. Multiply selects the low word (MUL) or the high word (the MULH variants). Quotient sign is signA^signB; remainder takes the sign of the dividend. result_out and rd_addr_out are registered. Next state is DONE.
- DONE: done_out=1 for this cycle only. Next state is IDLE. start_in is ignored in DONE.
- Special cases, with results required regardless of configuration:
  - Divide by zero: quotient is 0xFFFFFFFF; remainder equals rs1.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient is 0x80000000; remainder is 0.
- busy_out = (state==CALC) || (state==FIX). It is combinational from the state.
- flush_in: from any state the next state is IDLE. done_out is not asserted for the killed operation. flush_in has priority over start_in.
- result_out and rd_addr_out hold their value until the next completion.

## Timing
- Reset (asynchronous, rst_n=0): state is IDLE; busy_out, done_out, result_out and rd_addr_out are all 0; counter is 0.
- Request sampled at edge T. CALC spans cycles T+1..T+32. FIX is cycle T+33. done_out is high during cycle T+34, so fixed latency is 34 cycles.
- busy_out is high in cycles T+1..T+33 and low in cycle T+34, so the pipeline advances while done_out is high.
- A new request can be accepted at the edge ending cycle T+35 (IDLE) at the earliest.
- Reset asserted mid-operation aborts immediately with no done_out.

## Configuration
- MULDIV_EARLY_OUT_EN defined:
  - Early-out cases are divide-by-zero, signed overflow, and multiply with either operand equal to 0.
  - On acceptance in IDLE, an early-out case goes directly to DONE with the result registered, so done_out is high in cycle T+1.
  - busy_out never asserts for these cases.
- Undefined: all operations take the full 34-cycle latency with identical results.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD (-3) -> done_out at T+34, result_out=0xFFFFFFEB, rd_addr_out equals the latched rd; busy_out high for exactly 33 cycles.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM on the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV 100/0 -> 0xFFFFFFFF. REM 100/0 -> 0x64. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. Latency is T+1 with MULDIV_EARLY_OUT_EN and T+34 without.
- flush_in pulsed at cycle T+10 of a DIV -> IDLE at T+11, busy_out low, no done_out. A following MUL 3x4 -> 12 after 34 cycles.
- rst_n low at T+20 of a MUL -> all outputs 0 immediately. start_in held during reset is ignored. func7_in=0 with start_in=1 -> no busy_out, no done_out.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply,
// restoring divide, 32 iterations plus a sign-fix cycle. Optional MULDIV_EARLY_OUT_EN.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_in,
    input  logic [XLEN-1:0] rs1_data_in,
    input  logic [XLEN-1:0] rs2_data_in,
    input  logic [2:0]      func3_in,
    input  logic [6:0]      func7_in,
    input  logic [4:0]      rd_addr_in,
    input  logic            flush_in,
    output logic            busy_out,
    output logic            done_out,
    output logic [XLEN-1:0] result_out,
    output logic [4:0]      rd_addr_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    state_t      state_r, state_s;
    logic [4:0]  cnt_r, cnt_s;
    logic [63:0] acc_r, acc_s;
    logic [31:0] opd_r, opd_s;
    logic [2:0]  func3_r, func3_s;
    logic [4:0]  rd_r, rd_s;
    logic        neg_res_r, neg_res_s;
    logic        neg_rem_r, neg_rem_s;
    logic        div_zero_r, div_zero_s;
    logic [31:0] result_r, result_s;
    logic [4:0]  rd_out_r, rd_out_s;
    logic        done_r, done_s;

    logic        accept_s, is_div_s, signed_a_s, signed_b_s, sa_s, sb_s;
    logic        zero_div_s, ovf_s, early_s;
    logic [31:0] ma_mag_s, mb_mag_s, early_res_s;
    logic [32:0] mul_sum_s, rem_sh_s;
    logic [63:0] mul_next_s, div_next_s, prod_s;
    logic [31:0] diff_s, quot_s, rem_s, fix_res_s;
    logic        ge_s;

    assign accept_s   = start_in & (func7_in == 7'b0000001) & ~flush_in;
    assign is_div_s   = func3_in[2];
    assign signed_a_s = (func3_in == 3'd1) | (func3_in == 3'd2) | (func3_in == 3'd4) | (func3_in == 3'd6);
    assign signed_b_s = (func3_in == 3'd1) | (func3_in == 3'd4) | (func3_in == 3'd6);
    assign sa_s       = signed_a_s & rs1_data_in[31];
    assign sb_s       = signed_b_s & rs2_data_in[31];
    assign ma_mag_s   = sa_s ? neg32(rs1_data_in) : rs1_data_in;
    assign mb_mag_s   = sb_s ? neg32(rs2_data_in) : rs2_data_in;
    assign zero_div_s = is_div_s & (rs2_data_in == 32'h0000_0000);
    assign ovf_s      = is_div_s & ~func3_in[0] & (rs1_data_in == 32'h8000_0000)
                        & (rs2_data_in == 32'hFFFF_FFFF);

`ifdef MULDIV_EARLY_OUT_EN
    assign early_s = zero_div_s | ovf_s
                     | (~is_div_s & ((rs1_data_in == 32'h0000_0000) | (rs2_data_in == 32'h0000_0000)));
    // Early result: multiply by zero is 0; otherwise the divide special-case values.
    always_comb begin
        early_res_s = 32'h0000_0000;
        if (!is_div_s) begin
            early_res_s = 32'h0000_0000;
        end else if (zero_div_s) begin
            early_res_s = func3_in[1] ? rs1_data_in : 32'hFFFF_FFFF;
        end else begin
            early_res_s = func3_in[1] ? 32'h0000_0000 : 32'h8000_0000;
        end
    end
`else
    assign early_s     = 1'b0;
    assign early_res_s = 32'h0000_0000;
`endif

    // Multiply step: conditionally add the multiplicand to the high half, then shift right.
    assign mul_sum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opd_r} : 33'd0);
    assign mul_next_s = {mul_sum_s, acc_r[31:1]};

    // Divide step: shifted partial remainder can reach 33 bits before the trial subtract.
    assign rem_sh_s   = acc_r[63:31];
    assign ge_s       = (rem_sh_s >= {1'b0, opd_r});
    assign diff_s     = rem_sh_s[31:0] - opd_r;
    assign div_next_s = ge_s ? {diff_s, acc_r[30:0], 1'b1} : {rem_sh_s[31:0], acc_r[30:0], 1'b0};

    assign prod_s = neg_res_r ? neg64(acc_r) : acc_r;
    assign quot_s = div_zero_r ? 32'hFFFF_FFFF : (neg_res_r ? neg32(acc_r[31:0]) : acc_r[31:0]);
    assign rem_s  = neg_rem_r ? neg32(acc_r[63:32]) : acc_r[63:32];

    // Final result selection in the sign-fix cycle.
    always_comb begin
        fix_res_s = 32'h0000_0000;
        case (func3_r)
            3'd0:                fix_res_s = prod_s[31:0];
            3'd1, 3'd2, 3'd3:    fix_res_s = prod_s[63:32];
            3'd4, 3'd5:          fix_res_s = quot_s;
            3'd6, 3'd7:          fix_res_s = rem_s;
            default:             fix_res_s = 32'h0000_0000;
        endcase
    end

    // Next-state and datapath update; flush kills the operation without completing it.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        acc_s      = acc_r;
        opd_s      = opd_r;
        func3_s    = func3_r;
        rd_s       = rd_r;
        neg_res_s  = neg_res_r;
        neg_rem_s  = neg_rem_r;
        div_zero_s = div_zero_r;
        result_s   = result_r;
        rd_out_s   = rd_out_r;
        done_s     = 1'b0;
        if (flush_in) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        func3_s    = func3_in;
                        rd_s       = rd_addr_in;
                        cnt_s      = 5'd0;
                        neg_res_s  = sa_s ^ sb_s;
                        neg_rem_s  = sa_s;
                        div_zero_s = zero_div_s;
                        if (is_div_s) begin
                            acc_s = {32'h0000_0000, ma_mag_s};
                            opd_s = mb_mag_s;
                        end else begin
                            acc_s = {32'h0000_0000, mb_mag_s};
                            opd_s = ma_mag_s;
                        end
                        if (early_s) begin
                            result_s = early_res_s;
                            rd_out_s = rd_addr_in;
                            done_s   = 1'b1;
                            state_s  = DONE;
                        end else begin
                            state_s  = CALC;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                CALC: begin
                    acc_s = func3_r[2] ? div_next_s : mul_next_s;
                    cnt_s = cnt_r + 5'd1;
                    if (cnt_r == 5'd31) begin
                        state_s = FIX;
                    end else begin
                        state_s = CALC;
                    end
                end
                FIX: begin
                    result_s = fix_res_s;
                    rd_out_s = rd_r;
                    done_s   = 1'b1;
                    state_s  = DONE;
                end
                DONE: begin
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= 5'd0;
            acc_r      <= 64'd0;
            opd_r      <= 32'd0;
            func3_r    <= 3'd0;
            rd_r       <= 5'd0;
            neg_res_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            div_zero_r <= 1'b0;
            result_r   <= 32'd0;
            rd_out_r   <= 5'd0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            acc_r      <= acc_s;
            opd_r      <= opd_s;
            func3_r    <= func3_s;
            rd_r       <= rd_s;
            neg_res_r  <= neg_res_s;
            neg_rem_r  <= neg_rem_s;
            div_zero_r <= div_zero_s;
            result_r   <= result_s;
            rd_out_r   <= rd_out_s;
            done_r     <= done_s;
        end
    end

    assign busy_out    = (state_r == CALC) | (state_r == FIX);
    assign done_out    = done_r;
    assign result_out  = result_r;
    assign rd_addr_out = rd_out_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: arithmetic reference model plus per-cycle compare.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_in = 1'b0;
    logic [31:0] rs1_data_in = 32'd0;
    logic [31:0] rs2_data_in = 32'd0;
    logic [2:0]  func3_in = 3'd0;
    logic [6:0]  func7_in = 7'd0;
    logic [4:0]  rd_addr_in = 5'd0;
    logic        flush_in = 1'b0;
    logic        busy_out, done_out;
    logic [31:0] result_out;
    logic [4:0]  rd_addr_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Model of what the outputs must be
    int          exp_done_cyc = -1;
    int          busy_lo = 0;
    int          busy_hi = -1;
    logic [31:0] exp_res = 32'd0;
    logic [4:0]  exp_rd = 5'd0;
    logic [31:0] held_res = 32'd0;
    logic [4:0]  held_rd = 5'd0;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start_in(start_in),
        .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
        .func3_in(func3_in), .func7_in(func7_in), .rd_addr_in(rd_addr_in),
        .flush_in(flush_in), .busy_out(busy_out), .done_out(done_out),
        .result_out(result_out), .rd_addr_out(rd_addr_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ub, p;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        pu = {32'h0, a} * {32'h0, b};
        case (f3)
            3'd0: return pu[31:0];
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: return pu[63:32];
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic bit early(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (f3[2]) return (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (a == 32'd0) || (b == 32'd0);
`else
        return (f3 == 3'd0) && (a != a);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: every cycle, outputs against the model.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            held_res = 32'd0;
            held_rd  = 5'd0;
        end
        if (cyc == exp_done_cyc) begin
            held_res = exp_res;
            held_rd  = exp_rd;
        end
        chk("busy", {31'd0, busy_out}, {31'd0, (cyc >= busy_lo && cyc <= busy_hi)});
        chk("done", {31'd0, done_out}, {31'd0, (cyc == exp_done_cyc)});
        chk("result", result_out, held_res);
        chk("rd", {27'd0, rd_addr_out}, {27'd0, held_rd});
    end

    // Drive one request (called just after a rising edge); returns the acceptance-edge cycle.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [6:0] f7, input logic [31:0] hand,
                         output int t);
        chk("model_pin", model(f3, a, b), hand);
        start_in = 1'b1; func3_in = f3; rs1_data_in = a; rs2_data_in = b;
        rd_addr_in = rd; func7_in = f7;
        @(posedge clk); #1;
        start_in = 1'b0; func7_in = 7'd0;
        rs1_data_in = 32'hDEAD_BEEF; rs2_data_in = 32'h1234_5678; rd_addr_in = ~rd;
        t = cyc;
        if (f7 == 7'b0000001) begin
            exp_res = model(f3, a, b);
            exp_rd  = rd;
            busy_lo = t;
            if (early(f3, a, b)) begin
                exp_done_cyc = t;
                busy_hi = t - 1;
            end else begin
                exp_done_cyc = t + 33;
                busy_hi = t + 32;
            end
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$] = '{
        '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
        '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
        '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF},
        '{3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF},
        '{3'd3, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002},
        '{3'd0, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000},
        '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
        '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
        '{3'd5, 32'd100,       32'd7,         32'd14},
        '{3'd7, 32'd100,       32'd7,         32'd2},
        '{3'd4, 32'd100,       32'd0,         32'hFFFF_FFFF},
        '{3'd6, 32'd100,       32'd0,         32'h0000_0064},
        '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
        '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
        '{3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF},
        '{3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9},
        '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF},
        '{3'd7, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE},
        '{3'd5, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001}
    };

    initial begin
        int t;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back at the earliest acceptance point
        foreach (vecs[i]) begin
            issue(vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1), 7'b0000001, vecs[i].exp, t);
            repeat (34) @(posedge clk);
            #1;
        end

        // Flush a DIV in its tenth cycle, then a MUL completes normally
        issue(3'd4, 32'd1000, 32'd3, 5'd9, 7'b0000001, 32'd333, t);
        repeat (9) @(posedge clk);
        #1 flush_in = 1'b1;
        busy_hi = cyc;
        exp_done_cyc = -1;
        @(posedge clk); #1 flush_in = 1'b0;
        issue(3'd0, 32'd3, 32'd4, 5'd12, 7'b0000001, 32'd12, t);
        repeat (36) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a MUL; start held during reset
        issue(3'd0, 32'd6, 32'd7, 5'd3, 7'b0000001, 32'd42, t);
        repeat (19) @(posedge clk);
        #1 rst_n = 1'b0;
        start_in = 1'b1; func7_in = 7'b0000001; func3_in = 3'd0;
        rs1_data_in = 32'd5; rs2_data_in = 32'd6;
        busy_hi = cyc - 1;
        exp_done_cyc = -1;
        #1;
        chk("rst_busy", {31'd0, busy_out}, 32'd0);
        chk("rst_done", {31'd0, done_out}, 32'd0);
        chk("rst_result", result_out, 32'd0);
        chk("rst_rd", {27'd0, rd_addr_out}, 32'd0);
        repeat (3) @(posedge clk);
        #1 start_in = 1'b0; func7_in = 7'd0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Wrong func7 is ignored
        issue(3'd0, 32'd3, 32'd4, 5'd7, 7'b0000000, 32'd12, t);
        repeat (36) @(posedge clk);
        #1;

        // A normal op after all of that
        issue(3'd7, 32'd100, 32'd7, 5'd31, 7'b0000001, 32'd2, t);
        repeat (36) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
